// File: rtl/clk_lock_seq_if.sv
// Lock-sequencer signal bundle: PLL lock qualification in, reset/enable strobes and loss status out.
interface clk_lock_seq_if #(
  parameter int N_CH   = 4,
  parameter int DIV_W  = 16,
  parameter int LOSS_W = 8
);
  logic                    lock_in;
  logic [N_CH*DIV_W-1:0]   div_ratio;
  logic                    clr_lost;
  logic                    rst_out;
  logic                    locked;
  logic [N_CH-1:0]         ce;
  logic                    lock_lost;
  logic [LOSS_W-1:0]       loss_cnt;

  modport slave  (input lock_in, div_ratio, clr_lost,
                  output rst_out, locked, ce, lock_lost, loss_cnt);
  modport master (output lock_in, div_ratio, clr_lost,
                  input rst_out, locked, ce, lock_lost, loss_cnt);
endinterface

// File: rtl/clk_lock_seq.sv
// PLL lock qualifier: synchronises lock, holds downstream reset until lock is stable,
// then emits per-channel divided clock-enable strobes and tracks lock-loss events.
module clk_lock_seq_ch #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_entry,
  input  logic             run,
  input  logic [DIV_W-1:0] ratio_in,
  output logic             ce
);
  logic [DIV_W-1:0] ratio_q, ratio_d, cnt_q, cnt_d;

  always_comb begin
    ce      = run && (ratio_q != '0) && (cnt_q == ratio_q - DIV_W'(1));
    ratio_d = ratio_q;
    cnt_d   = '0;
    // Ratio is only sampled on run entry so mid-run edits cannot glitch the phase.
    if (run_entry)                          ratio_d = ratio_in;
    else if (run && ratio_q != '0 && !ce)   cnt_d   = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ratio_q <= '0;
      cnt_q   <= '0;
    end else begin
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module clk_lock_seq #(
  parameter int N_CH       = 4,
  parameter int DIV_W      = 16,
  parameter int STABLE_CYC = 1024,
  parameter int LOSS_W     = 8
) (
  input  logic           clk,
  input  logic           reset,
  clk_lock_seq_if.slave  bus
);
  localparam int SC_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;

  typedef enum logic [1:0] {S_WAIT, S_STAB, S_RUN, S_LOST} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, lock_s_q;
  logic [SC_W-1:0]   stab_q, stab_d;
  logic              rst_out_q, rst_out_d;
  logic              locked_q, locked_d;
  logic              lock_lost_q, lock_lost_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              run, run_entry;
  logic [N_CH-1:0]   ce_w;

  always_comb begin
    state_d     = state_q;
    stab_d      = stab_q;
    loss_d      = loss_q;
    lock_lost_d = bus.clr_lost ? 1'b0 : lock_lost_q;
    case (state_q)
      S_WAIT: begin
        stab_d = '0;
        if (lock_s_q) state_d = S_STAB;
      end
      S_STAB: begin
        // A dropped lock outranks completion and restarts qualification.
        if (!lock_s_q) begin
          state_d = S_WAIT;
          stab_d  = '0;
        end else if (stab_q == SC_W'(STABLE_CYC-1)) begin
          state_d = S_RUN;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + SC_W'(1);
        end
      end
      S_RUN: begin
        stab_d = '0;
        if (!lock_s_q) state_d = S_LOST;
      end
      S_LOST: begin
        state_d     = S_WAIT;
        lock_lost_d = 1'b1;
        if (loss_q != '1) loss_d = loss_q + LOSS_W'(1);
      end
      default: state_d = S_WAIT;
    endcase
    rst_out_d = (state_d != S_RUN);
    locked_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      stab_q      <= '0;
      rst_out_q   <= 1'b1;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.lock_in;
      lock_s_q    <= sync1_q;
      stab_q      <= stab_d;
      rst_out_q   <= rst_out_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      loss_q      <= loss_d;
    end
  end

  assign run       = (state_q == S_RUN);
  assign run_entry = (state_d == S_RUN) && !run;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_lock_seq_ch #(.DIV_W(DIV_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .run_entry (run_entry),
      .run       (run),
      .ratio_in  (bus.div_ratio[i*DIV_W +: DIV_W]),
      .ce        (ce_w[i])
    );
  end

  assign bus.rst_out   = rst_out_q;
  assign bus.locked    = locked_q;
  assign bus.ce        = ce_w;
  assign bus.lock_lost = lock_lost_q;
  assign bus.loss_cnt  = loss_q;
endmodule

// File: tb/tb_clk_lock_seq.sv
// Directed bench for clk_lock_seq with STABLE_CYC=16 (release 19 edges after lock rises).
module tb_clk_lock_seq;
  logic clk;
  logic reset;
  int   vecs = 0;
  int   errs = 0;
  int   exp_loss = 0;

  clk_lock_seq_if #(.N_CH(4), .DIV_W(16), .LOSS_W(8)) bus ();

  clk_lock_seq #(.N_CH(4), .DIV_W(16), .STABLE_CYC(16), .LOSS_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ratios(input logic [15:0] r0, r1, r2, r3);
    bus.div_ratio = {r3, r2, r1, r0};
  endtask

  // Raise lock and count edges until rst_out falls.
  task automatic lock_and_release(input string name);
    int n;
    n = 0;
    bus.lock_in = 1'b1;
    do begin
      tick();
      n++;
    end while (bus.rst_out !== 1'b0 && n < 40);
    vecs++;
    if (n != 19) begin
      errs++;
      $display("FAIL %s release_latency got=%0d want=19", name, n);
    end
    vecs++;
    if (bus.locked !== 1'b1) begin
      errs++;
      $display("FAIL %s locked got=%b want=1", name, bus.locked);
    end
  endtask

  task automatic drop_lock(input string name);
    bus.lock_in = 1'b0;
    repeat (3) tick();
    vecs++;
    if (bus.rst_out !== 1'b1 || bus.locked !== 1'b0 || bus.ce !== 4'h0) begin
      errs++;
      $display("FAIL %s loss_outputs got rst=%b lk=%b ce=%h want rst=1 lk=0 ce=0",
               name, bus.rst_out, bus.locked, bus.ce);
    end
    tick();
    if (exp_loss < 255) exp_loss++;
    vecs++;
    if (bus.lock_lost !== 1'b1 || bus.loss_cnt !== 8'(exp_loss)) begin
      errs++;
      $display("FAIL %s loss_flags got lost=%b cnt=%0d want lost=1 cnt=%0d",
               name, bus.lock_lost, bus.loss_cnt, exp_loss);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.lock_in = 1'b0;
    bus.clr_lost = 1'b0;
    set_ratios(16'd1, 16'd1, 16'd1, 16'd1);
    tick();
    tick();
    vecs++;
    if (bus.rst_out !== 1'b1 || bus.locked !== 1'b0 || bus.ce !== 4'h0 ||
        bus.lock_lost !== 1'b0 || bus.loss_cnt !== 8'd0) begin
      errs++;
      $display("FAIL reset_values got rst=%b lk=%b ce=%h lost=%b cnt=%0d",
               bus.rst_out, bus.locked, bus.ce, bus.lock_lost, bus.loss_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  // Dropout seen at stable count 10; release lands 19 edges after the re-raise.
  task automatic test_glitch();
    set_ratios(16'd0, 16'd1, 16'd3, 16'd10);
    bus.lock_in = 1'b1;
    repeat (11) tick();
    bus.lock_in = 1'b0;
    tick();
    lock_and_release("glitch");
    vecs++;
    if (bus.lock_lost !== 1'b0 || bus.loss_cnt !== 8'd0) begin
      errs++;
      $display("FAIL glitch_no_loss got lost=%b cnt=%0d want 0/0", bus.lock_lost, bus.loss_cnt);
    end
  endtask

  task automatic test_divider();
    logic [3:0] exp_ce;
    for (int k = 0; k < 30; k++) begin
      exp_ce = {(k % 10 == 9), (k % 3 == 2), 1'b1, 1'b0};
      vecs++;
      if (bus.ce !== exp_ce) begin
        errs++;
        $display("FAIL divider idx=%0d got=%b want=%b", k, bus.ce, exp_ce);
      end
      tick();
    end
  endtask

  task automatic test_lock_loss();
    drop_lock("loss");
    lock_and_release("relock");
    vecs++;
    if (bus.lock_lost !== 1'b1) begin
      errs++;
      $display("FAIL loss_sticky got=%b want=1", bus.lock_lost);
    end
  endtask

  task automatic test_ratio_change();
    drop_lock("ratio_drop1");
    set_ratios(16'd4, 16'd0, 16'd0, 16'd0);
    lock_and_release("ratio4");
    for (int k = 0; k < 16; k++) begin
      if (k == 5) set_ratios(16'd2, 16'd0, 16'd0, 16'd0);
      vecs++;
      if (bus.ce[0] !== (k % 4 == 3)) begin
        errs++;
        $display("FAIL ratio_held idx=%0d got=%b want=%b", k, bus.ce[0], (k % 4 == 3));
      end
      tick();
    end
    drop_lock("ratio_drop2");
    lock_and_release("ratio2");
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if (bus.ce[0] !== (k % 2 == 1)) begin
        errs++;
        $display("FAIL ratio_new idx=%0d got=%b want=%b", k, bus.ce[0], (k % 2 == 1));
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      drop_lock("sat");
      lock_and_release("sat_relock");
    end
    vecs++;
    if (bus.loss_cnt !== 8'd255) begin
      errs++;
      $display("FAIL saturate got=%0d want=255", bus.loss_cnt);
    end
  endtask

  task automatic test_clr_lost();
    bus.clr_lost = 1'b1;
    tick();
    bus.clr_lost = 1'b0;
    vecs++;
    if (bus.lock_lost !== 1'b0) begin
      errs++;
      $display("FAIL clr_alone1 got=%b want=0", bus.lock_lost);
    end
    bus.lock_in = 1'b0;
    repeat (3) tick();
    bus.clr_lost = 1'b1;
    tick();
    bus.clr_lost = 1'b0;
    vecs++;
    if (bus.lock_lost !== 1'b1 || bus.loss_cnt !== 8'd255) begin
      errs++;
      $display("FAIL set_wins got lost=%b cnt=%0d want lost=1 cnt=255", bus.lock_lost, bus.loss_cnt);
    end
    tick();
    bus.clr_lost = 1'b1;
    tick();
    bus.clr_lost = 1'b0;
    vecs++;
    if (bus.lock_lost !== 1'b0) begin
      errs++;
      $display("FAIL clr_alone2 got=%b want=0", bus.lock_lost);
    end
  endtask

  task automatic test_async_reset();
    set_ratios(16'd1, 16'd1, 16'd1, 16'd1);
    lock_and_release("pre_areset");
    vecs++;
    if (bus.ce !== 4'hF) begin
      errs++;
      $display("FAIL areset_pre_ce got=%h want=f", bus.ce);
    end
    #2 reset = 1'b1;
    #1;
    vecs++;
    if (bus.rst_out !== 1'b1 || bus.locked !== 1'b0 || bus.ce !== 4'h0 || bus.loss_cnt !== 8'd0) begin
      errs++;
      $display("FAIL areset_immediate got rst=%b lk=%b ce=%h cnt=%0d want 1/0/0/0",
               bus.rst_out, bus.locked, bus.ce, bus.loss_cnt);
    end
    tick();
    reset = 1'b0;
    lock_and_release("post_areset");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_divider();
    test_lock_loss();
    test_ratio_change();
    test_saturation();
    test_clr_lost();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
